unified_mem_arbiter: RTL and testbench
======================================

// Module: unified_mem_arbiter
// PURPOSE
//  Shares one single-port synchronous SRAM (SP_SRAM, 1-cycle read latency) between the
//  core's instruction-fetch port and data-access port for a unified-memory build.
//  Data side has priority (older instruction in MEM); a starvation counter forces an
//  instruction grant after STARVE_MAX consecutive data wins. Sits between RISCV_TOP and memory.
// PARAMETERS
//  AWIDTH      12  SRAM word-address width; word index = byte addr[AWIDTH+1:2]
//  DWIDTH      32  data width
//  STARVE_MAX  4   max consecutive D grants while I_REQ pending (1..15)
// PORTS
//  CLK      in   1       clock, all state on rising edge
//  RST      in   1       synchronous reset, active-high
//  I_REQ    in   1       fetch read request; I_ADDR held stable until I_GNT
//  I_ADDR   in   32      fetch byte address
//  I_GNT    out  1       fetch accepted this cycle
//  I_RVALID out  1       fetch data valid (cycle after I_GNT)
//  I_RDATA  out  DWIDTH  fetch data; 0 when I_RVALID=0
//  D_REQ    in   1       data request; D_* held stable until D_GNT
//  D_WE     in   1       1=write, 0=read
//  D_BE     in   4       byte enables for writes, bit n = byte n
//  D_ADDR   in   32      data byte address
//  D_WDATA  in   DWIDTH  write data
//  D_GNT    out  1       data access accepted this cycle
//  D_RVALID out  1       read data valid (cycle after a read D_GNT; never for writes)
//  D_RDATA  out  DWIDTH  read data; 0 when D_RVALID=0
//  M_CSN    out  1       SRAM chip select, active-low
//  M_WEN    out  1       SRAM write enable, active-low
//  M_BE     out  4       D_BE on write grant, 4'b0000 otherwise
//  M_ADDR   out  AWIDTH  SRAM word address; 0 when idle
//  M_DI     out  DWIDTH  D_WDATA on write grant, 0 otherwise
//  M_DOUT   in   DWIDTH  SRAM read data (valid cycle after read select)
// BEHAVIOUR
//  - Reset (RST=1 at edge): GNTs/RVALIDs 0, M_CSN=1, M_WEN=1, M_BE=0, M_ADDR=0, M_DI=0,
//    RDATAs 0, starvation count 0, response owner NONE. Response owed at reset is dropped.
//  - Grant is combinational, same cycle as request; at most one GNT per cycle.
//  - Arbitration: only D_REQ -> D; only I_REQ -> I; both -> D unless cnt==STARVE_MAX,
//    then I. Neither -> idle (CSN=1).
//  - cnt: +1 on each D grant while I_REQ=1 and I not granted; cleared on I grant or
//    when I_REQ=0; saturates at STARVE_MAX.
//  - On grant drive M_CSN=0, M_ADDR=addr[AWIDTH+1:2] (upper bits, addr[1:0] ignored),
//    M_WEN=~D_WE for D, 1 for I.
//  - Registered owner (NONE/I/D) set at a read grant; next cycle that side's RVALID=1 and
//    RDATA=M_DOUT. Back-to-back reads each cycle sustained (throughput 1/cycle).
//  - Write grant: owner NONE; write lands at the edge; no RVALID.
//  - Read-after-write same address in consecutive cycles returns new data (SRAM order).
// STRUCTURE
//  - Shared pkg/header: owner encoding OWN_NONE=2'd0, OWN_I=2'd1, OWN_D=2'd2;
//    default STARVE_MAX.
//  - One sub-module: mem_arb_starve_ctr (saturating counter, clear/inc, at_max flag).
//  - Top: combinational grant/mux + owner register + response demux.
// TESTING
//  1 Reset: RST=1 two cycles, I_REQ=D_REQ=1 -> no GNT, M_CSN=1, RVALIDs 0; release -> D_GNT.
//  2 I only: I_ADDR=0x10, M_DOUT=0xDEADBEEF next cycle -> I_GNT, M_ADDR=4, then
//    I_RVALID=1, I_RDATA=0xDEADBEEF, D_RVALID=0.
//  3 D write/read: D_WE=1,D_BE=4'b0011,D_ADDR=0x20,D_WDATA=0x12345678 -> M_WEN=0,M_BE=0011,
//    M_ADDR=8, no D_RVALID; next read 0x20 -> D_RVALID, D_RDATA=0x00005678 (mem init 0).
//  4 Starvation: both REQ held, STARVE_MAX=4 -> grants D,D,D,D,I,D,D,D,D,I ...
//  5 Reset mid-read: I read granted, RST=1 next edge -> I_RVALID stays 0, owner NONE.
//  6 Back-to-back: alternating I/D reads 8 cycles -> each RVALID on owning side only,
//    data matches address-keyed memory model, no lost or duplicated responses.

Source files
------------

// File: rtl/unified_mem_arbiter_pkg.sv
// Shared types for the unified I/D memory arbiter.
// Response owner encoding and starvation counter sizing.
package unified_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

  localparam int STARVE_MAX_DEF = 4;
  localparam int CNT_W          = 4;

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Saturating count of consecutive data wins over a waiting fetch.
// Clear dominates increment; at_max_o forces the next fetch grant.
module mem_arb_starve_ctr
  import unified_mem_arbiter_pkg::*;
#(
  parameter int MAX = STARVE_MAX_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic inc_i,
  output logic at_max_o
);

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != MAX_C)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_max_o = (cnt_q == MAX_C);

endmodule

// File: rtl/unified_mem_arbiter.sv
// Fetch/data arbiter in front of one single-port SRAM.
// Data wins ties unless the fetch side has starved too long.
module unified_mem_arbiter
  import unified_mem_arbiter_pkg::*;
#(
  parameter int AWIDTH     = 12,
  parameter int DWIDTH     = 32,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              I_REQ,
  input  logic [31:0]       I_ADDR,
  output logic              I_GNT,
  output logic              I_RVALID,
  output logic [DWIDTH-1:0] I_RDATA,
  input  logic              D_REQ,
  input  logic              D_WE,
  input  logic [3:0]        D_BE,
  input  logic [31:0]       D_ADDR,
  input  logic [DWIDTH-1:0] D_WDATA,
  output logic              D_GNT,
  output logic              D_RVALID,
  output logic [DWIDTH-1:0] D_RDATA,
  output logic              M_CSN,
  output logic              M_WEN,
  output logic [3:0]        M_BE,
  output logic [AWIDTH-1:0] M_ADDR,
  output logic [DWIDTH-1:0] M_DI,
  input  logic [DWIDTH-1:0] M_DOUT
);

  owner_e owner_q, owner_d;
  logic   at_max;
  logic   i_win, d_win;

  assign i_win = I_REQ && (!D_REQ || at_max);
  assign d_win = D_REQ && !i_win;

  always_comb begin
    I_GNT   = 1'b0;
    D_GNT   = 1'b0;
    M_CSN   = 1'b1;
    M_WEN   = 1'b1;
    M_BE    = 4'b0000;
    M_ADDR  = '0;
    M_DI    = '0;
    owner_d = OWN_NONE;
    if (!RST) begin
      unique case (1'b1)
        i_win: begin
          I_GNT   = 1'b1;
          M_CSN   = 1'b0;
          M_ADDR  = I_ADDR[AWIDTH+1:2];
          owner_d = OWN_I;
        end
        d_win: begin
          D_GNT  = 1'b1;
          M_CSN  = 1'b0;
          M_WEN  = ~D_WE;
          M_ADDR = D_ADDR[AWIDTH+1:2];
          if (D_WE) begin
            M_BE = D_BE;
            M_DI = D_WDATA;
          end else begin
            owner_d = OWN_D;
          end
        end
        default: ;
      endcase
    end
  end

  // A waiting fetch accrues a strike only when data takes the slot.
  mem_arb_starve_ctr #(
    .MAX (STARVE_MAX)
  ) u_starve (
    .clk_i    (CLK),
    .rst_i    (RST),
    .clr_i    (I_GNT || !I_REQ),
    .inc_i    (D_GNT && I_REQ),
    .at_max_o (at_max)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      owner_q <= OWN_NONE;
    end else begin
      owner_q <= owner_d;
    end
  end

  // Reset also hides a response already owed from the prior cycle.
  assign I_RVALID = !RST && (owner_q == OWN_I);
  assign D_RVALID = !RST && (owner_q == OWN_D);
  assign I_RDATA  = I_RVALID ? M_DOUT : '0;
  assign D_RDATA  = D_RVALID ? M_DOUT : '0;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{I_ADDR[31:AWIDTH+2], I_ADDR[1:0],
                              D_ADDR[31:AWIDTH+2], D_ADDR[1:0]};

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Scoreboard bench for unified_mem_arbiter with a behavioural SRAM.
// Driver pushes expected read responses; monitor pops on RVALID.
module tb_unified_mem_arbiter;

  logic        CLK;
  logic        RST;
  logic        I_REQ;
  logic [31:0] I_ADDR;
  logic        I_GNT;
  logic        I_RVALID;
  logic [31:0] I_RDATA;
  logic        D_REQ;
  logic        D_WE;
  logic [3:0]  D_BE;
  logic [31:0] D_ADDR;
  logic [31:0] D_WDATA;
  logic        D_GNT;
  logic        D_RVALID;
  logic [31:0] D_RDATA;
  logic        M_CSN;
  logic        M_WEN;
  logic [3:0]  M_BE;
  logic [11:0] M_ADDR;
  logic [31:0] M_DI;
  logic [31:0] M_DOUT;

  typedef struct {
    logic        side;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mem [4096];
  int          n_cmp = 0;
  int          n_err = 0;

  unified_mem_arbiter dut (
    .CLK      (CLK),
    .RST      (RST),
    .I_REQ    (I_REQ),
    .I_ADDR   (I_ADDR),
    .I_GNT    (I_GNT),
    .I_RVALID (I_RVALID),
    .I_RDATA  (I_RDATA),
    .D_REQ    (D_REQ),
    .D_WE     (D_WE),
    .D_BE     (D_BE),
    .D_ADDR   (D_ADDR),
    .D_WDATA  (D_WDATA),
    .D_GNT    (D_GNT),
    .D_RVALID (D_RVALID),
    .D_RDATA  (D_RDATA),
    .M_CSN    (M_CSN),
    .M_WEN    (M_WEN),
    .M_BE     (M_BE),
    .M_ADDR   (M_ADDR),
    .M_DI     (M_DI),
    .M_DOUT   (M_DOUT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (!M_CSN) begin
      if (!M_WEN) begin
        for (int b = 0; b < 4; b++) begin
          if (M_BE[b]) mem[M_ADDR][8*b +: 8] <= M_DI[8*b +: 8];
        end
      end else begin
        M_DOUT <= mem[M_ADDR];
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic flag(input string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s", nm);
  endtask

  task automatic step(
    input logic        rst,
    input logic        ir,
    input logic [31:0] ia,
    input logic        dr,
    input logic        dwe,
    input logic [3:0]  dbe,
    input logic [31:0] da,
    input logic [31:0] dwd,
    input logic        eig,
    input logic        edg,
    input logic [31:0] erd,
    input string       nm
  );
    logic [11:0] ea;
    @(posedge CLK);
    #1;
    RST = rst; I_REQ = ir; I_ADDR = ia;
    D_REQ = dr; D_WE = dwe; D_BE = dbe;
    D_ADDR = da; D_WDATA = dwd;
    if (rst) sb.delete();
    ea = eig ? ia[13:2] : (edg ? da[13:2] : 12'h0);
    @(negedge CLK);
    chk({nm, " I_GNT"}, 32'(I_GNT), 32'(eig));
    chk({nm, " D_GNT"}, 32'(D_GNT), 32'(edg));
    chk({nm, " M_CSN"}, 32'(M_CSN), 32'(!(eig || edg)));
    chk({nm, " M_ADDR"}, 32'(M_ADDR), 32'(ea));
    chk({nm, " M_WEN"}, 32'(M_WEN), 32'(edg ? !dwe : 1'b1));
    chk({nm, " M_BE"}, 32'(M_BE), 32'((edg && dwe) ? dbe : 4'h0));
    chk({nm, " M_DI"}, M_DI, (edg && dwe) ? dwd : 32'h0);
    if (eig) sb.push_back('{side: 1'b0, data: erd});
    if (edg && !dwe) sb.push_back('{side: 1'b1, data: erd});
  endtask

  task automatic idle(input string nm);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, nm);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge CLK);
      if (I_RVALID && D_RVALID) begin
        flag("both RVALID high");
      end else if (I_RVALID || D_RVALID) begin
        if (sb.size() == 0) begin
          flag("unexpected response");
        end else begin
          e = sb.pop_front();
          chk("rsp side", 32'(D_RVALID), 32'(e.side));
          chk("rsp data", D_RVALID ? D_RDATA : I_RDATA, e.data);
          chk("other RDATA", D_RVALID ? I_RDATA : D_RDATA, 32'h0);
        end
      end else begin
        chk("idle I_RDATA", I_RDATA, 32'h0);
        chk("idle D_RDATA", D_RDATA, 32'h0);
      end
    end
  end

  initial begin : driver
    for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
    mem[4]     = 32'hDEADBEEF;
    mem[12'h40] = 32'h1111_0040;
    mem[12'h80] = 32'h2222_0080;
    for (int i = 16; i < 24; i++) mem[i] = 32'hC0DE_0000 | 32'(i);
    M_DOUT = 32'h0;
    RST = 1'b1; I_REQ = 1'b0; I_ADDR = 0;
    D_REQ = 1'b0; D_WE = 1'b0; D_BE = 0; D_ADDR = 0; D_WDATA = 0;

    step(1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, "rst1");
    chk("rst1 I_RVALID", 32'(I_RVALID), 32'h0);
    chk("rst1 D_RVALID", 32'(D_RVALID), 32'h0);
    step(1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, "rst2");
    chk("rst2 I_RVALID", 32'(I_RVALID), 32'h0);
    step(0, 1, 0, 1, 0, 0, 0, 0, 0, 1, 32'h0, "release");
    idle("idle0");

    step(0, 1, 32'h10, 0, 0, 0, 0, 0, 1, 0, 32'hDEADBEEF, "i_only");
    idle("idle1");

    step(0, 0, 0, 1, 1, 4'b0011, 32'h20, 32'h12345678,
         0, 1, 0, "d_write");
    step(0, 0, 0, 1, 0, 0, 32'h20, 0, 0, 1, 32'h0000_5678, "d_read");
    idle("idle2");

    for (int i = 0; i < 10; i++) begin
      step(0, 1, 32'h100, 1, 0, 0, 32'h200, 0,
           (i % 5) == 4, (i % 5) != 4,
           ((i % 5) == 4) ? 32'h1111_0040 : 32'h2222_0080, "starve");
    end
    idle("idle3");

    step(0, 1, 32'h10, 0, 0, 0, 0, 0, 1, 0, 32'hDEADBEEF, "pre_rst");
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "mid_rst");
    chk("mid_rst I_RVALID", 32'(I_RVALID), 32'h0);
    idle("post_rst");
    chk("post_rst I_RVALID", 32'(I_RVALID), 32'h0);

    for (int i = 0; i < 8; i++) begin
      if ((i % 2) == 0) begin
        step(0, 1, 32'((16 + i) * 4), 0, 0, 0, 0, 0,
             1, 0, 32'hC0DE_0000 | 32'(16 + i), "b2b_i");
      end else begin
        step(0, 0, 0, 1, 0, 0, 32'((16 + i) * 4), 0,
             0, 1, 32'hC0DE_0000 | 32'(16 + i), "b2b_d");
      end
    end
    idle("idle4");
    idle("idle5");
    chk("scoreboard drained", 32'(sb.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
